// File: rtl/serial_pattern_scan_if.sv
// Handshake bundle between the word producer and the serial pattern scan controller.
// The master modport is the producer/consumer side; the slave modport is the controller.
interface serial_pattern_scan_if #(
    parameter int DATA_W    = 8,
    parameter int PAT_W_MAX = 8,
    parameter int CNT_W     = 8
);
    localparam int LEN_W = $clog2(PAT_W_MAX) + 1;

    logic                 cfg_valid;
    logic [PAT_W_MAX-1:0] cfg_pattern;
    logic [LEN_W-1:0]     cfg_len;
    logic                 cfg_ready;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic                 in_last;
    logic                 in_ready;
    logic                 bit_valid;
    logic                 bit_out;
    logic                 hit;
    logic [CNT_W-1:0]     match_count;
    logic                 done;
    logic                 busy;

    modport master (
        output cfg_valid, cfg_pattern, cfg_len, in_valid, in_data, in_last,
        input  cfg_ready, in_ready, bit_valid, bit_out, hit, match_count, done, busy
    );

    modport slave (
        input  cfg_valid, cfg_pattern, cfg_len, in_valid, in_data, in_last,
        output cfg_ready, in_ready, bit_valid, bit_out, hit, match_count, done, busy
    );
endinterface

// File: rtl/serial_pattern_scan_controller.sv
// Frame controller: serializes words MSB-first into a history register and counts
// overlapping pattern matches per frame, with one-cycle hit and done pulses.
//
// state | meaning
// IDLE  | waiting for a configuration; cfg_ready high
// LOAD  | waiting for the next word of the frame; in_ready high
// SHIFT | scanning one bit per cycle of the latched word
// DONE  | one-cycle end-of-frame pulse; match_count is final
module serial_pattern_scan_controller #(
    parameter int DATA_W    = 8,
    parameter int PAT_W_MAX = 8,
    parameter int CNT_W     = 8
) (
    input logic              clk,
    input logic              rst,
    serial_pattern_scan_if.slave bus
);
    localparam int LEN_W = $clog2(PAT_W_MAX) + 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

    state_t               state;
    logic [PAT_W_MAX-1:0] pattern_q;
    logic [LEN_W-1:0]     len_q;
    logic [PAT_W_MAX-1:0] hist_q;
    logic [LEN_W-1:0]     fill_q;
    logic [DATA_W-1:0]    word_q;
    logic [IDX_W-1:0]     idx_q;
    logic                 last_q;
    logic                 cfg_ready_q;
    logic                 in_ready_q;
    logic                 bit_valid_q;
    logic                 bit_out_q;
    logic                 hit_q;
    logic                 done_q;
    logic                 busy_q;
    logic [CNT_W-1:0]     count_q;

    logic [PAT_W_MAX-1:0] hist_next;
    logic [PAT_W_MAX-1:0] mask;
    logic [LEN_W-1:0]     fill_next;
    logic [LEN_W-1:0]     len_eff;
    logic                 match;

    // Match is judged on the history as it will look after this cycle's shift.
    always_comb begin
        hist_next = (hist_q << 1) | {{(PAT_W_MAX-1){1'b0}}, bit_out_q};
        fill_next = (fill_q == LEN_W'(PAT_W_MAX)) ? fill_q : fill_q + LEN_W'(1);
        mask = '0;
        for (int i = 0; i < PAT_W_MAX; i++) begin
            mask[i] = (i < int'(len_q));
        end
        match = (fill_next >= len_q) && (((hist_next ^ pattern_q) & mask) == '0);
        if (bus.cfg_len == '0) begin
            len_eff = LEN_W'(1);
        end else if (bus.cfg_len > LEN_W'(PAT_W_MAX)) begin
            len_eff = LEN_W'(PAT_W_MAX);
        end else begin
            len_eff = bus.cfg_len;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pattern_q   <= '0;
            len_q       <= LEN_W'(1);
            hist_q      <= '0;
            fill_q      <= '0;
            word_q      <= '0;
            idx_q       <= '0;
            last_q      <= 1'b0;
            cfg_ready_q <= 1'b1;
            in_ready_q  <= 1'b0;
            bit_valid_q <= 1'b0;
            bit_out_q   <= 1'b0;
            hit_q       <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
            count_q     <= '0;
        end else begin
            hit_q  <= 1'b0;
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.cfg_valid) begin
                        state       <= LOAD;
                        pattern_q   <= bus.cfg_pattern;
                        len_q       <= len_eff;
                        hist_q      <= '0;
                        fill_q      <= '0;
                        count_q     <= '0;
                        cfg_ready_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                LOAD: begin
                    if (bus.in_valid) begin
                        state       <= SHIFT;
                        bit_out_q   <= bus.in_data[DATA_W-1];
                        word_q      <= bus.in_data << 1;
                        idx_q       <= IDX_W'(DATA_W - 1);
                        last_q      <= bus.in_last;
                        in_ready_q  <= 1'b0;
                        bit_valid_q <= 1'b1;
                    end
                end
                SHIFT: begin
                    hist_q <= hist_next;
                    fill_q <= fill_next;
                    hit_q  <= match;
                    if (match && count_q != '1) begin
                        count_q <= count_q + CNT_W'(1);
                    end
                    if (idx_q == '0) begin
                        bit_valid_q <= 1'b0;
                        bit_out_q   <= 1'b0;
                        if (last_q) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state      <= LOAD;
                            in_ready_q <= 1'b1;
                        end
                    end else begin
                        idx_q     <= idx_q - IDX_W'(1);
                        bit_out_q <= word_q[DATA_W-1];
                        word_q    <= word_q << 1;
                    end
                end
                DONE: begin
                    state       <= IDLE;
                    busy_q      <= 1'b0;
                    cfg_ready_q <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cfg_ready   = cfg_ready_q;
    assign bus.in_ready    = in_ready_q;
    assign bus.bit_valid   = bit_valid_q;
    assign bus.bit_out     = bit_out_q;
    assign bus.hit         = hit_q;
    assign bus.match_count = count_q;
    assign bus.done        = done_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_serial_pattern_scan_controller.sv
// Directed bench for serial_pattern_scan_controller: hit timing, cross-word matches,
// saturation, backpressure with ignored config, and asynchronous mid-frame reset.
module tb_serial_pattern_scan_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   passes = 0;
    int   fails  = 0;

    always #5 clk = ~clk;

    serial_pattern_scan_if #(.DATA_W(8), .PAT_W_MAX(8), .CNT_W(8)) ifa ();
    serial_pattern_scan_if #(.DATA_W(8), .PAT_W_MAX(8), .CNT_W(3)) ifb ();

    serial_pattern_scan_controller #(.DATA_W(8), .PAT_W_MAX(8), .CNT_W(8)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    serial_pattern_scan_controller #(.DATA_W(8), .PAT_W_MAX(8), .CNT_W(3)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:1] exp_bits(input logic [7:0] d);
        logic [9:1] r;
        for (int k = 1; k <= 8; k++) r[k] = d[8-k];
        r[9] = 1'b0;
        return r;
    endfunction

    task automatic configure(input logic [7:0] pat, input logic [3:0] len);
        ifa.cfg_valid   = 1'b1;
        ifa.cfg_pattern = pat;
        ifa.cfg_len     = len;
        tick();
        ifa.cfg_valid   = 1'b0;
        ifa.cfg_pattern = 8'h00;
        ifa.cfg_len     = 4'd0;
    endtask

    // Handshakes one word, then samples cycles w+1..w+9; returns in cycle w+9.
    task automatic run_word(input logic [7:0] data, input logic last, input int poke_k,
                            output logic [9:1] hv, output logic [9:1] dv,
                            output logic [9:1] bo, output logic [9:1] bv);
        ifa.in_valid = 1'b1;
        ifa.in_data  = data;
        ifa.in_last  = last;
        tick();
        ifa.in_valid = 1'b0;
        ifa.in_data  = ~data;
        ifa.in_last  = ~last;
        for (int k = 1; k <= 9; k++) begin
            hv[k] = ifa.hit;
            dv[k] = ifa.done;
            bo[k] = ifa.bit_out;
            bv[k] = ifa.bit_valid;
            ifa.cfg_valid   = (k == poke_k);
            ifa.cfg_pattern = 8'hFF;
            ifa.cfg_len     = 4'd1;
            if (k < 9) tick();
        end
        ifa.cfg_valid   = 1'b0;
        ifa.cfg_pattern = 8'h00;
        ifa.cfg_len     = 4'd0;
        ifa.in_last     = 1'b0;
    endtask

    initial begin
        logic [9:1] hv, dv, bo, bv;
        logic       wait_ok;
        int         hcount;
        logic [2:0] cnt_k8;
        logic       done_k9;

        ifa.cfg_valid = 1'b0; ifa.cfg_pattern = '0; ifa.cfg_len = '0;
        ifa.in_valid  = 1'b0; ifa.in_data = '0; ifa.in_last = 1'b0;
        ifb.cfg_valid = 1'b0; ifb.cfg_pattern = '0; ifb.cfg_len = '0;
        ifb.in_valid  = 1'b0; ifb.in_data = '0; ifb.in_last = 1'b0;

        // Reset state
        tick();
        tick();
        check("reset_flags", {ifa.cfg_ready, ifa.in_ready, ifa.bit_valid, ifa.bit_out,
                              ifa.hit, ifa.done, ifa.busy}, 7'b1000000);
        check("reset_count", ifa.match_count, 8'd0);
        rst = 1'b0;
        tick();

        // Overlapping matches in one word
        configure(8'b0000_1010, 4'd4);
        check("cfg_to_load", {ifa.cfg_ready, ifa.in_ready, ifa.busy, ifa.bit_valid}, 4'b0110);
        run_word(8'hAA, 1'b1, 0, hv, dv, bo, bv);
        check("ovl_hits", hv, 9'b101010000);
        check("ovl_done", dv, 9'b100000000);
        check("ovl_bits", bo, exp_bits(8'hAA));
        check("ovl_bit_valid", bv, 9'b011111111);
        check("ovl_count_at_done", ifa.match_count, 8'd3);
        tick();
        check("ovl_idle", {ifa.cfg_ready, ifa.busy, ifa.done}, 3'b100);
        tick();
        check("ovl_count_holds", ifa.match_count, 8'd3);

        // Match across a word boundary
        configure(8'b0000_0110, 4'd4);
        check("xw_count_cleared", ifa.match_count, 8'd0);
        run_word(8'h03, 1'b0, 0, hv, dv, bo, bv);
        check("xw_word1_hits", hv, 9'b000000000);
        check("xw_back_to_load", {ifa.in_ready, ifa.bit_valid, ifa.busy}, 3'b101);
        run_word(8'h00, 1'b1, 0, hv, dv, bo, bv);
        check("xw_word2_hits", hv, 9'b000000010);
        check("xw_done", dv, 9'b100000000);
        check("xw_count", ifa.match_count, 8'd1);
        tick();

        // Length clamp (0 -> 1) and 3-bit counter saturation
        ifb.cfg_valid   = 1'b1;
        ifb.cfg_pattern = 8'h01;
        ifb.cfg_len     = 4'd0;
        tick();
        ifb.cfg_valid   = 1'b0;
        ifb.in_valid    = 1'b1;
        ifb.in_data     = 8'hFF;
        ifb.in_last     = 1'b1;
        tick();
        ifb.in_valid    = 1'b0;
        ifb.in_last     = 1'b0;
        hcount  = 0;
        cnt_k8  = '0;
        done_k9 = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            if (ifb.hit) hcount++;
            if (k == 8) cnt_k8 = ifb.match_count;
            if (k == 9) done_k9 = ifb.done;
            if (k < 9) tick();
        end
        check("sat_hit_pulses", hcount, 8);
        check("sat_count_k8", cnt_k8, 3'd7);
        check("sat_count_final", ifb.match_count, 3'd7);
        check("sat_done", done_k9, 1'b1);
        tick();

        // Backpressure in LOAD with ignored config pulses
        configure(8'b0000_1010, 4'd4);
        wait_ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            wait_ok = wait_ok & ifa.in_ready & ifa.busy & ~ifa.bit_valid;
            ifa.cfg_valid   = (i == 2);
            ifa.cfg_pattern = 8'hFF;
            ifa.cfg_len     = 4'd1;
            tick();
        end
        ifa.cfg_valid = 1'b0;
        check("bp_wait_flags", wait_ok, 1'b1);
        check("bp_still_load", {ifa.in_ready, ifa.busy, ifa.cfg_ready}, 3'b110);
        run_word(8'hAA, 1'b1, 3, hv, dv, bo, bv);
        check("bp_hits", hv, 9'b101010000);
        check("bp_count", ifa.match_count, 8'd3);
        tick();

        // Asynchronous reset mid-SHIFT, then a clean frame
        configure(8'b0000_1010, 4'd4);
        ifa.in_valid = 1'b1;
        ifa.in_data  = 8'hAA;
        ifa.in_last  = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
        ifa.in_last  = 1'b0;
        for (int k = 1; k < 5; k++) tick();
        check("rst_pre_state", {ifa.bit_valid, ifa.bit_out, ifa.hit, ifa.match_count},
              {3'b111, 8'd1});
        #2;
        rst = 1'b1;
        #1;
        check("rst_async_flags", {ifa.cfg_ready, ifa.in_ready, ifa.bit_valid, ifa.bit_out,
                                  ifa.hit, ifa.done, ifa.busy}, 7'b1000000);
        check("rst_async_count", ifa.match_count, 8'd0);
        #2;
        rst = 1'b0;
        tick();
        check("rst_idle", {ifa.cfg_ready, ifa.busy}, 2'b10);
        configure(8'b0000_1010, 4'd4);
        run_word(8'hAA, 1'b1, 0, hv, dv, bo, bv);
        check("rst_new_hits", hv, 9'b101010000);
        check("rst_new_count", ifa.match_count, 8'd3);
        tick();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
